// File: rtl/bg_reg_file.sv
// Background register file: CPU-writable BG control/scroll/affine registers plus the
// running BG2/BG3 affine reference points, stepped per scanline and reloaded at vblank.
module bg_reg_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_be,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic        vblank_start,
  input  logic        line_done,
  output logic [15:0] bg0cnt, bg1cnt, bg2cnt, bg3cnt,
  output logic [15:0] bg0hofs, bg1hofs, bg2hofs, bg3hofs,
  output logic [15:0] bg0vofs, bg1vofs, bg2vofs, bg3vofs,
  output logic [15:0] bg2pa, bg2pb, bg2pc, bg2pd,
  output logic [15:0] bg3pa, bg3pb, bg3pc, bg3pd,
  output logic [27:0] bg2x, bg2y, bg3x, bg3y
);

  localparam logic [15:0] CNT_MASK = 16'hFFCF;

  function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] be);
    return {(be[1] ? new_v[15:8] : old_v[15:8]), (be[0] ? new_v[7:0] : old_v[7:0])};
  endfunction

  function automatic logic [8:0] ofs_merge(input logic [8:0] old_v, input logic [15:0] new_v,
                                           input logic [1:0] be);
    logic [15:0] m;
    m = merge16({7'd0, old_v}, new_v, be);
    return m[8:0];
  endfunction

  function automatic logic [27:0] latch_merge(input logic [27:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
    logic [31:0] m;
    m = {merge16({4'd0, old_v[27:16]}, new_v[31:16], be[3:2]), merge16(old_v[15:0], new_v[15:0], be[1:0])};
    return m[27:0];
  endfunction

  // Register storage; aff_r order is bg2 pa,pb,pc,pd then bg3 pa,pb,pc,pd.
  // latch_r/ref_r order is bg2x, bg2y, bg3x, bg3y.
  logic [15:0] cnt_r   [4];
  logic [8:0]  hofs_r  [4];
  logic [8:0]  vofs_r  [4];
  logic [15:0] aff_r   [8];
  logic [27:0] latch_r [4];
  logic [27:0] ref_r   [4];
  logic [31:0] rdata_r;

  logic [5:0]  word_s;
  logic [3:0]  cnt_hit_s, ofs_hit_s, latch_hit_s;
  logic [7:0]  aff_hit_s;
  logic [3:0]  cnt_we_s, ofs_we_s, latch_we_s;
  logic [7:0]  aff_we_s;
  logic [31:0] rd_val_s;
  logic [15:0] cnt_nxt_s   [4];
  logic [8:0]  hofs_nxt_s  [4];
  logic [8:0]  vofs_nxt_s  [4];
  logic [15:0] aff_nxt_s   [8];
  logic [27:0] latch_nxt_s [4];
  logic [27:0] step_s      [4];

  // Address decode and readback mux (reads see pre-write register values).
  always_comb begin
    word_s      = io_addr[7:2];
    cnt_hit_s   = 4'b0000;
    ofs_hit_s   = 4'b0000;
    aff_hit_s   = 8'h00;
    latch_hit_s = 4'b0000;
    rd_val_s    = 32'h0000_0000;
    case (word_s)
      6'd2:    begin cnt_hit_s = 4'b0011; rd_val_s = {cnt_r[1], cnt_r[0]}; end
      6'd3:    begin cnt_hit_s = 4'b1100; rd_val_s = {cnt_r[3], cnt_r[2]}; end
      6'd4:    ofs_hit_s   = 4'b0001;
      6'd5:    ofs_hit_s   = 4'b0010;
      6'd6:    ofs_hit_s   = 4'b0100;
      6'd7:    ofs_hit_s   = 4'b1000;
      6'd8:    aff_hit_s   = 8'h03;
      6'd9:    aff_hit_s   = 8'h0C;
      6'd10:   latch_hit_s = 4'b0001;
      6'd11:   latch_hit_s = 4'b0010;
      6'd12:   aff_hit_s   = 8'h30;
      6'd13:   aff_hit_s   = 8'hC0;
      6'd14:   latch_hit_s = 4'b0100;
      6'd15:   latch_hit_s = 4'b1000;
      default: rd_val_s    = 32'h0000_0000;
    endcase
    cnt_we_s   = cnt_hit_s & {4{io_we}};
    ofs_we_s   = ofs_hit_s & {4{io_we}};
    aff_we_s   = aff_hit_s & {8{io_we}};
    latch_we_s = latch_hit_s & {4{io_we & (|io_be)}};
  end

  // Byte-merged next values and sign-extended per-line steps (PB for X, PD for Y).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_nxt_s[i]   = merge16(cnt_r[i], i[0] ? io_wdata[31:16] : io_wdata[15:0],
                               i[0] ? io_be[3:2] : io_be[1:0]) & CNT_MASK;
      hofs_nxt_s[i]  = ofs_merge(hofs_r[i], io_wdata[15:0], io_be[1:0]);
      vofs_nxt_s[i]  = ofs_merge(vofs_r[i], io_wdata[31:16], io_be[3:2]);
      latch_nxt_s[i] = latch_merge(latch_r[i], io_wdata, io_be);
      step_s[i]      = {{12{aff_r[2*i+1][15]}}, aff_r[2*i+1]};
    end
    for (int j = 0; j < 8; j++) begin
      aff_nxt_s[j] = merge16(aff_r[j], j[0] ? io_wdata[31:16] : io_wdata[15:0],
                             j[0] ? io_be[3:2] : io_be[1:0]);
    end
  end

  // CPU-visible register state; PA/PD reset to the identity transform.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i]   <= 16'h0000;
        hofs_r[i]  <= 9'd0;
        vofs_r[i]  <= 9'd0;
        latch_r[i] <= 28'd0;
      end
      for (int j = 0; j < 8; j++) begin
        aff_r[j] <= ((j % 4) == 0 || (j % 4) == 3) ? 16'h0100 : 16'h0000;
      end
      rdata_r <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_we_s[i])   cnt_r[i]   <= cnt_nxt_s[i];
        if (ofs_we_s[i])   hofs_r[i]  <= hofs_nxt_s[i];
        if (ofs_we_s[i])   vofs_r[i]  <= vofs_nxt_s[i];
        if (latch_we_s[i]) latch_r[i] <= latch_nxt_s[i];
      end
      for (int j = 0; j < 8; j++) begin
        if (aff_we_s[j]) aff_r[j] <= aff_nxt_s[j];
      end
      if (io_re) rdata_r <= rd_val_s;
    end
  end

  // Running reference points: CPU write beats vblank reload, which beats line stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) ref_r[i] <= 28'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (latch_we_s[i])     ref_r[i] <= latch_nxt_s[i];
        else if (vblank_start) ref_r[i] <= latch_r[i];
        else if (line_done)    ref_r[i] <= ref_r[i] + step_s[i];
      end
    end
  end

  assign io_rdata = rdata_r;
  assign bg0cnt  = cnt_r[0];
  assign bg1cnt  = cnt_r[1];
  assign bg2cnt  = cnt_r[2];
  assign bg3cnt  = cnt_r[3];
  assign bg0hofs = {7'd0, hofs_r[0]};
  assign bg1hofs = {7'd0, hofs_r[1]};
  assign bg2hofs = {7'd0, hofs_r[2]};
  assign bg3hofs = {7'd0, hofs_r[3]};
  assign bg0vofs = {7'd0, vofs_r[0]};
  assign bg1vofs = {7'd0, vofs_r[1]};
  assign bg2vofs = {7'd0, vofs_r[2]};
  assign bg3vofs = {7'd0, vofs_r[3]};
  assign bg2pa   = aff_r[0];
  assign bg2pb   = aff_r[1];
  assign bg2pc   = aff_r[2];
  assign bg2pd   = aff_r[3];
  assign bg3pa   = aff_r[4];
  assign bg3pb   = aff_r[5];
  assign bg3pc   = aff_r[6];
  assign bg3pd   = aff_r[7];
  assign bg2x    = ref_r[0];
  assign bg2y    = ref_r[1];
  assign bg3x    = ref_r[2];
  assign bg3y    = ref_r[3];

endmodule

// File: tb/tb_bg_reg_file.sv
// Directed table-driven bench for bg_reg_file: one vector per clock, one output checked per vector.
module tb_bg_reg_file;

  logic        clock, reset;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_we, io_re, vblank_start, line_done;
  logic [31:0] io_rdata;
  logic [15:0] bg0cnt, bg1cnt, bg2cnt, bg3cnt;
  logic [15:0] bg0hofs, bg1hofs, bg2hofs, bg3hofs, bg0vofs, bg1vofs, bg2vofs, bg3vofs;
  logic [15:0] bg2pa, bg2pb, bg2pc, bg2pd, bg3pa, bg3pb, bg3pc, bg3pd;
  logic [27:0] bg2x, bg2y, bg3x, bg3y;

  bg_reg_file dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata), .vblank_start(vblank_start),
    .line_done(line_done),
    .bg0cnt(bg0cnt), .bg1cnt(bg1cnt), .bg2cnt(bg2cnt), .bg3cnt(bg3cnt),
    .bg0hofs(bg0hofs), .bg1hofs(bg1hofs), .bg2hofs(bg2hofs), .bg3hofs(bg3hofs),
    .bg0vofs(bg0vofs), .bg1vofs(bg1vofs), .bg2vofs(bg2vofs), .bg3vofs(bg3vofs),
    .bg2pa(bg2pa), .bg2pb(bg2pb), .bg2pc(bg2pc), .bg2pd(bg2pd),
    .bg3pa(bg3pa), .bg3pb(bg3pb), .bg3pc(bg3pc), .bg3pd(bg3pd),
    .bg2x(bg2x), .bg2y(bg2y), .bg3x(bg3x), .bg3y(bg3y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags = {we, re, vblank_start, line_done}
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  flags;
    int          sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // sel: 0-3 cnt, 4-7 hofs, 8-11 vofs, 12-19 bg2pa..bg3pd, 20-23 bg2x,bg2y,bg3x,bg3y, 24 io_rdata
  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return {16'd0, bg0cnt};   1: return {16'd0, bg1cnt};
      2: return {16'd0, bg2cnt};   3: return {16'd0, bg3cnt};
      4: return {16'd0, bg0hofs};  5: return {16'd0, bg1hofs};
      6: return {16'd0, bg2hofs};  7: return {16'd0, bg3hofs};
      8: return {16'd0, bg0vofs};  9: return {16'd0, bg1vofs};
      10: return {16'd0, bg2vofs}; 11: return {16'd0, bg3vofs};
      12: return {16'd0, bg2pa};   13: return {16'd0, bg2pb};
      14: return {16'd0, bg2pc};   15: return {16'd0, bg2pd};
      16: return {16'd0, bg3pa};   17: return {16'd0, bg3pb};
      18: return {16'd0, bg3pc};   19: return {16'd0, bg3pd};
      20: return {4'd0, bg2x};     21: return {4'd0, bg2y};
      22: return {4'd0, bg3x};     23: return {4'd0, bg3y};
      24: return io_rdata;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic vec_t mk(logic [7:0] a, logic [31:0] d, logic [3:0] b, logic [3:0] f,
                              int s, logic [31:0] e);
    vec_t v;
    v.addr = a; v.wdata = d; v.be = b; v.flags = f; v.sel = s; v.exp = e;
    return v;
  endfunction

  task automatic check(string nm, int sel, logic [31:0] exp);
    logic [31:0] got;
    got = obs(sel);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s sel=%0d: got %h, expected %h", nm, sel, got, exp);
    end
  endtask

  task automatic idle();
    io_addr = 8'h00; io_wdata = 32'h0; io_be = 4'h0;
    io_we = 1'b0; io_re = 1'b0; vblank_start = 1'b0; line_done = 1'b0;
  endtask

  task automatic check_reset(string nm);
    for (int s = 0; s < 25; s++)
      check(nm, s, (s == 12 || s == 15 || s == 16 || s == 19) ? 32'h0000_0100 : 32'h0);
  endtask

  localparam logic [3:0] W = 4'b1000, R = 4'b0100, VB = 4'b0010, LD = 4'b0001, I = 4'b0000;

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset("reset");
    reset = 1'b0;

    vecs.push_back(mk(8'h08, 32'hC3FF_A5B7, 4'b0101, W,     0, 32'h0000_0087));
    vecs.push_back(mk(8'h08, 32'h0,         4'h0,    R,    24, 32'h00CF_0087));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,     1, 32'h0000_00CF));
    vecs.push_back(mk(8'h0C, 32'hFFFF_FFFF, 4'hF,    W,     2, 32'h0000_FFCF));
    vecs.push_back(mk(8'h0C, 32'h0,         4'h0,    R,    24, 32'hFFCF_FFCF));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,     3, 32'h0000_FFCF));
    vecs.push_back(mk(8'h08, 32'h1234_5678, 4'hF,    W,     0, 32'h0000_5648));
    vecs.push_back(mk(8'h08, 32'h0,         4'hF,    W|R,  24, 32'h1204_5648));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,     1, 32'h0));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    24, 32'h1204_5648));
    vecs.push_back(mk(8'h08, 32'h0,         4'h0,    R,    24, 32'h0));
    vecs.push_back(mk(8'h10, 32'hFFFF_FFFF, 4'hF,    W,     4, 32'h0000_01FF));
    vecs.push_back(mk(8'h0C, 32'h0,         4'h0,    R,     8, 32'h0000_01FF));
    vecs.push_back(mk(8'h10, 32'h0,         4'h0,    R,    24, 32'h0));
    vecs.push_back(mk(8'h40, 32'hFFFF_FFFF, 4'hF,    W,     2, 32'h0000_FFCF));
    vecs.push_back(mk(8'h1C, 32'h0003_0102, 4'b0011, W,     7, 32'h0000_0102));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    11, 32'h0));
    vecs.push_back(mk(8'h28, 32'h0001_0000, 4'hF,    W,    20, 32'h0001_0000));
    vecs.push_back(mk(8'h20, 32'hFF80_0000, 4'b1100, W,    13, 32'h0000_FF80));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    12, 32'h0000_0100));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    LD,   20, 32'h0000_FF80));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    LD,   20, 32'h0000_FF00));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    LD,   20, 32'h0000_FE80));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    21, 32'h0000_0300));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    VB,   20, 32'h0001_0000));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    21, 32'h0));
    vecs.push_back(mk(8'h28, 32'h0000_00AB, 4'b0001, W,    20, 32'h0001_00AB));
    vecs.push_back(mk(8'h3C, 32'hFFFF_FFFF, 4'hF,    W,    23, 32'h0FFF_FFFF));
    vecs.push_back(mk(8'h34, 32'h0001_0000, 4'b1100, W,    19, 32'h0000_0001));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    LD,   23, 32'h0));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    20, 32'h0001_002B));
    vecs.push_back(mk(8'h20, 32'h0040_0000, 4'b1100, W|LD, 20, 32'h0000_FFAB));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    13, 32'h0000_0040));
    vecs.push_back(mk(8'h2C, 32'h0000_0500, 4'hF,    W,    21, 32'h0000_0500));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    LD,   21, 32'h0000_0600));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    20, 32'h0000_FFEB));
    vecs.push_back(mk(8'h28, 32'h0222_2222, 4'hF,    W|VB|LD, 20, 32'h0222_2222));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    21, 32'h0000_0500));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    23, 32'h0FFF_FFFF));
    vecs.push_back(mk(8'h28, 32'h0000_1000, 4'hF,    W|LD, 20, 32'h0000_1000));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    21, 32'h0000_0600));
    vecs.push_back(mk(8'h30, 32'h0010_0000, 4'b1100, W,    17, 32'h0000_0010));
    vecs.push_back(mk(8'h38, 32'h0000_0100, 4'hF,    W,    22, 32'h0000_0100));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    LD,   22, 32'h0000_0110));
    vecs.push_back(mk(8'h24, 32'h8001_7FFF, 4'hF,    W,    14, 32'h0000_7FFF));
    vecs.push_back(mk(8'h00, 32'h0,         4'h0,    I,    15, 32'h0000_8001));
    vecs.push_back(mk(8'h18, 32'h0000_01FF, 4'b0001, W,     6, 32'h0000_00FF));

    foreach (vecs[k]) begin
      io_addr      = vecs[k].addr;
      io_wdata     = vecs[k].wdata;
      io_be        = vecs[k].be;
      io_we        = vecs[k].flags[3];
      io_re        = vecs[k].flags[2];
      vblank_start = vecs[k].flags[1];
      line_done    = vecs[k].flags[0];
      @(posedge clock);
      #1;
      idle();
      check($sformatf("vec%0d", k), vecs[k].sel, vecs[k].exp);
    end

    // Reset mid-frame with a latch write, vblank and line_done all on the same edge.
    reset = 1'b1; io_we = 1'b1; io_addr = 8'h28; io_wdata = 32'h0FFF_FFFF; io_be = 4'hF;
    vblank_start = 1'b1; line_done = 1'b1;
    @(posedge clock);
    #1;
    idle();
    check_reset("midframe_reset");
    reset = 1'b0;
    line_done = 1'b1;
    @(posedge clock);
    #1;
    idle();
    check("post_reset_step_y", 21, 32'h0000_0100);
    check("post_reset_step_x", 20, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
